// File: rtl/fft_bin_reducer.sv
// fft_bin_reducer
//   On a `ready` pulse, walks 2^(HADDR_W+DECIM_LOG2) bins of the FFT magnitude
//   buffer starting at `fhead`. Every 2^DECIM_LOG2 consecutive bins are reduced
//   (max, or saturating sum) to one histogram entry.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   ready         : start pulse; fhead/mode sampled with it
//   faddr / fdata : FFT BRAM read port, data READ_LAT cycles after address
//   haddr / hdata / hwe : histogram BRAM write port
//   busy, done    : pass in progress / one-cycle completion pulse
//   error         : sticky, set by a start request that arrives while busy
//   peak_bin / peak_val : (FFT_PEAK_TRACK_EN only) largest entry of the pass
//
// Optional feature macro: FFT_PEAK_TRACK_EN
module fft_bin_reducer #(
  parameter int FADDR_W    = 12,
  parameter int FDATA_W    = 16,
  parameter int HADDR_W    = 10,
  parameter int HDATA_W    = 16,
  parameter int DECIM_LOG2 = 2,
  parameter int READ_LAT   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic [FADDR_W-1:0] fhead,
  input  logic               mode,
  output logic [FADDR_W-1:0] faddr,
  input  logic [FDATA_W-1:0] fdata,
  output logic [HADDR_W-1:0] haddr,
  output logic [HDATA_W-1:0] hdata,
  output logic               hwe,
  output logic               busy,
  output logic               done,
  output logic               error
`ifdef FFT_PEAK_TRACK_EN
  ,
  output logic [HADDR_W-1:0] peak_bin,
  output logic [HDATA_W-1:0] peak_val
`endif
);

  localparam int CW = HADDR_W + DECIM_LOG2;  // sample index width
  localparam int AW = FDATA_W + DECIM_LOG2;  // accumulator width, sum cannot overflow
  localparam logic [CW-1:0] GMASK = CW'((1 << DECIM_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [FADDR_W-1:0] fhead_q;
  logic               mode_q;
  logic [CW-1:0]      iss_cnt, cap_cnt;
  logic [READ_LAT:0]  vld_pipe;
  logic [AW-1:0]      acc, fext, comb_v;
  logic [HDATA_W-1:0] red;
  logic               accept, issue_last, wr_last;
  logic               cap, grp_first, grp_last;

  // The done cycle still counts as busy, so a start then is refused.
  always_comb begin
    accept     = ready && (state == IDLE) && !done;
    issue_last = (state == RUN) && (iss_cnt == '1);
    state_nx   = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (issue_last) state_nx = DRAIN;
      DRAIN:   if (wr_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reduction datapath: vld_pipe[READ_LAT] marks the cycle fdata belongs to a read.
  always_comb begin
    cap       = vld_pipe[READ_LAT];
    fext      = AW'(fdata);
    grp_first = (cap_cnt & GMASK) == '0;
    grp_last  = (cap_cnt & GMASK) == GMASK;
    if (grp_first)   comb_v = fext;
    else if (mode_q) comb_v = acc + fext;
    else             comb_v = (fext > acc) ? fext : acc;
  end

  generate
    if (AW > HDATA_W) begin : g_clamp
      always_comb red = (|comb_v[AW-1:HDATA_W]) ? '1 : comb_v[HDATA_W-1:0];
    end else begin : g_ext
      always_comb red = HDATA_W'(comb_v);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fhead_q  <= '0;
      mode_q   <= 1'b0;
      iss_cnt  <= '0;
      cap_cnt  <= '0;
      vld_pipe <= '0;
      acc      <= '0;
      faddr    <= '0;
      haddr    <= '0;
      hdata    <= '0;
      hwe      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      wr_last  <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != IDLE);
      done     <= (state == DRAIN) && wr_last;
      hwe      <= 1'b0;
      wr_last  <= 1'b0;
      vld_pipe <= {vld_pipe[READ_LAT-1:0], state == RUN};

      if (accept) begin
        fhead_q <= fhead;
        mode_q  <= mode;
        error   <= 1'b0;
        iss_cnt <= '0;
        cap_cnt <= '0;
      end else if (ready) begin
        error <= 1'b1;
      end

      // Address wraps silently in FADDR_W bits.
      if (state == RUN) begin
        faddr   <= fhead_q + FADDR_W'(iss_cnt);
        iss_cnt <= iss_cnt + 1'b1;
      end

      if (cap) begin
        acc     <= comb_v;
        cap_cnt <= cap_cnt + 1'b1;
        if (grp_last) begin
          hwe     <= 1'b1;
          haddr   <= HADDR_W'(cap_cnt >> DECIM_LOG2);
          hdata   <= red;
          wr_last <= (cap_cnt == '1);
        end
      end
    end
  end

`ifdef FFT_PEAK_TRACK_EN
  // Strict compare keeps the lowest bin index on ties.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      peak_bin <= '0;
      peak_val <= '0;
    end else if (cap && grp_last && (red > peak_val)) begin
      peak_bin <= HADDR_W'(cap_cnt >> DECIM_LOG2);
      peak_val <= red;
    end
  end
`endif

endmodule
